uart_tx_async: RTL and testbench

- Asynchronous UART transmitter; the companion of the UART receiver in the CoreUARTapb core.
- Serialises a byte into a start/data/parity/stop frame on the tx line, one bit per 16 baud_clock enable pulses.
- Sits between the APB register/TX FIFO logic and the tx pin.
- Frame format is bit-compatible with the receiver: LSB first, 7/8 data bits, optional even/odd parity, one stop bit.

---
 rtl/uart_tx_async.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_async.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_async.sv
// uart_tx_async: byte-to-frame UART transmitter (start, 7/8 data LSB first,
// optional even/odd parity, one stop), one bit per 16 baud_clock pulses.
// Ports: clk, reset_n (async, active low), baud_clock (16x enable),
//   bit8/parity_en/odd_n_even (frame config), tx_data, write_tx_byte,
//   fifo_empty, fifo_read_en (TX_FIFO=1 refill), tx, tx_ready, tx_idle.
module uart_tx_async #(
  parameter int TX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic [7:0] tx_data,
  input  logic       write_tx_byte,
  input  logic       fifo_empty,
  output logic       fifo_read_en,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_idle
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state, state_d;
  logic [3:0] bit_timer, timer_d;
  logic [2:0] bit_cnt, cnt_d;
  logic [7:0] shift, shift_d;
  logic [7:0] hold;
  logic       par, par_d, par_nx;
  logic       tx_d;
  logic       bit8_f, bit8_d;
  logic       pe_f, pe_d;
  logic       odd_f, odd_d;
  logic       load;
  logic       take;
  logic       rd_d;
  logic       last_bit;
  logic       boundary;

  localparam logic USE_FIFO = (TX_FIFO != 0);

  // last data bit index is 7 for 8-bit frames, 6 for 7-bit frames
  assign last_bit = (bit_cnt == {2'b11, bit8_f});
  assign boundary = &bit_timer;
  assign par_nx   = par ^ shift[0];

  // FIFO mode: pulse the pop, take the show-ahead data on the next clk
  assign take = USE_FIFO ? fifo_read_en : (write_tx_byte & tx_ready);
  assign rd_d = USE_FIFO & tx_ready & ~fifo_empty & ~fifo_read_en;

  assign tx_idle = (state == IDLE) & tx_ready;

  always_comb begin
    state_d = state;
    timer_d = bit_timer;
    cnt_d   = bit_cnt;
    shift_d = shift;
    par_d   = par;
    tx_d    = tx;
    bit8_d  = bit8_f;
    pe_d    = pe_f;
    odd_d   = odd_f;
    load    = 1'b0;
    if (baud_clock) begin
      timer_d = bit_timer + 4'd1;
      unique case (state)
        IDLE: begin
          timer_d = '0;
          tx_d    = 1'b1;
          load    = ~tx_ready;
        end
        START: begin
          if (boundary) begin
            state_d = DATA;
            tx_d    = shift[0];
            cnt_d   = '0;
          end
        end
        DATA: begin
          if (boundary) begin
            par_d   = par_nx;
            shift_d = {1'b0, shift[7:1]};
            if (last_bit) begin
              if (pe_f) begin
                state_d = PARITY;
                tx_d    = par_nx ^ odd_f;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              cnt_d = bit_cnt + 3'd1;
              tx_d  = shift[1];
            end
          end
        end
        PARITY: begin
          if (boundary) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
        STOP: begin
          if (boundary) begin
            if (tx_ready) state_d = IDLE;
            else          load    = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
      // frame start: shared by IDLE and back-to-back from STOP
      if (load) begin
        state_d = START;
        tx_d    = 1'b0;
        timer_d = '0;
        cnt_d   = '0;
        shift_d = hold;
        par_d   = 1'b0;
        bit8_d  = bit8;
        pe_d    = parity_en;
        odd_d   = odd_n_even;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      tx        <= 1'b1;
      bit8_f    <= 1'b1;
      pe_f      <= 1'b0;
      odd_f     <= 1'b0;
    end else begin
      state     <= state_d;
      bit_timer <= timer_d;
      bit_cnt   <= cnt_d;
      shift     <= shift_d;
      par       <= par_d;
      tx        <= tx_d;
      bit8_f    <= bit8_d;
      pe_f      <= pe_d;
      odd_f     <= odd_d;
    end
  end

  // load only fires with tx_ready=0, take only with tx_ready=1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold         <= '0;
      tx_ready     <= 1'b1;
      fifo_read_en <= 1'b0;
    end else begin
      fifo_read_en <= rd_d;
      if (load) begin
        tx_ready <= 1'b1;
      end else if (take) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_async.sv
// tb_uart_tx_async: directed bench for uart_tx_async in holding-register
// mode (u0) and TX FIFO mode (u1), baud_clock tied high.
module tb_uart_tx_async;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_clock;
  logic       bit8, parity_en, odd_n_even;
  logic [7:0] tx_data0;
  logic       write_tx_byte0;
  logic       fifo_read_en0, tx0, tx_ready0, tx_idle0;
  logic [7:0] tx_data1;
  logic       fifo_empty1;
  logic       fifo_read_en1, tx1, tx_ready1, tx_idle1;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int rp = 0;
  int fifo_n = 0;
  logic [7:0] fmem [2];

  always #5 clk = ~clk;

  uart_tx_async #(.TX_FIFO(0)) u0 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .tx_data(tx_data0), .write_tx_byte(write_tx_byte0),
    .fifo_empty(1'b1), .fifo_read_en(fifo_read_en0),
    .tx(tx0), .tx_ready(tx_ready0), .tx_idle(tx_idle0)
  );

  uart_tx_async #(.TX_FIFO(1)) u1 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .tx_data(tx_data1), .write_tx_byte(1'b0),
    .fifo_empty(fifo_empty1), .fifo_read_en(fifo_read_en1),
    .tx(tx1), .tx_ready(tx_ready1), .tx_idle(tx_idle1)
  );

  // show-ahead FIFO model
  assign fifo_empty1 = (rp >= fifo_n);
  assign tx_data1 = (rp < 2) ? fmem[rp] : 8'h00;

  always @(posedge clk) begin
    if (fifo_read_en1 === 1'b1) begin
      rp <= rp + 1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic b8, input logic pe, input logic odd);
    @(posedge clk);
    #1;
    bit8 = b8;
    parity_en = pe;
    odd_n_even = odd;
  endtask

  task automatic write0(input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_data0 = b;
    write_tx_byte0 = 1'b1;
    @(posedge clk);
    #1;
    write_tx_byte0 = 1'b0;
  endtask

  // exp: frame bits in send order, bit 0 = start bit
  task automatic frame(input bit sel, input logic [10:0] exp,
                       input int nb, input int max_wait,
                       input bit exp_idle, input string tag);
    bit found;
    logic t;
    logic [10:0] got;
    found = 1'b0;
    got = '0;
    for (int w = 0; w <= max_wait && !found; w++) begin
      @(negedge clk);
      t = sel ? tx1 : tx0;
      if (t === 1'b0) found = 1'b1;
    end
    chk({31'd0, found}, 32'd1, {tag, "_start"});
    if (found) begin
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < 16; j++) begin
          if (b != 0 || j != 0) @(negedge clk);
          t = sel ? tx1 : tx0;
          if (j == 0) got[b] = t;
          else if (t !== got[b]) got[b] = 1'bx;
        end
      end
      chk({21'd0, got}, {21'd0, exp}, {tag, "_bits"});
      if (exp_idle) begin
        @(negedge clk);
        chk({31'd0, sel ? tx_idle1 : tx_idle0}, 32'd1, {tag, "_idle"});
        chk({31'd0, sel ? tx1 : tx0}, 32'd1, {tag, "_txhi"});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    fmem[0] = 8'h12;
    fmem[1] = 8'h34;
    reset_n = 1'b0;
    baud_clock = 1'b1;
    bit8 = 1'b1;
    parity_en = 1'b0;
    odd_n_even = 1'b0;
    tx_data0 = 8'h00;
    write_tx_byte0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({31'd0, tx0}, 32'd1, "rst_tx");
    chk({31'd0, tx_ready0}, 32'd1, "rst_ready");
    chk({31'd0, tx_idle0}, 32'd1, "rst_idle");
    chk({31'd0, fifo_read_en0}, 32'd0, "rst_rd0");
    chk({31'd0, fifo_read_en1}, 32'd0, "rst_rd1");
    chk({31'd0, tx1}, 32'd1, "rst_tx1");
    reset_n = 1'b1;

    // FIFO empty: no pops, line stays high
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    chk(lows, 0, "empty_tx1");
    chk(rd_cnt, 0, "empty_rd");

    // reset in the middle of a DATA bit
    write0(8'h5A);
    chk({31'd0, tx_ready0}, 32'd0, "wr_ready0");
    repeat (50) @(posedge clk);
    #1;
    chk({31'd0, tx0}, 32'd0, "mid_tx");
    chk({31'd0, tx_idle0}, 32'd0, "mid_idle");
    reset_n = 1'b0;
    #1;
    chk({31'd0, tx0}, 32'd1, "arst_tx");
    chk({31'd0, tx_ready0}, 32'd1, "arst_ready");
    chk({31'd0, tx_idle0}, 32'd1, "arst_idle");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 8N1 0x55
    write0(8'h55);
    frame(1'b0, {2'b01, 8'h55, 1'b0}, 10, 5, 1'b1, "f8n1_55");

    // 7E1 0xC3: 1,1,0,0,0,0,1 then parity 1
    cfg(1'b0, 1'b1, 1'b0);
    write0(8'hC3);
    frame(1'b0, {2'b11, 7'h43, 1'b0}, 10, 5, 1'b1, "f7e1_c3");

    // 8O1 / 8E1 with 0xFF
    cfg(1'b1, 1'b1, 1'b1);
    write0(8'hFF);
    frame(1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 11, 5, 1'b1, "f8o1_ff");
    cfg(1'b1, 1'b1, 1'b0);
    write0(8'hFF);
    frame(1'b0, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, 5, 1'b1, "f8e1_ff");

    // back-to-back, third write ignored
    cfg(1'b1, 1'b0, 1'b0);
    write0(8'hA5);
    fork
      frame(1'b0, {2'b01, 8'hA5, 1'b0}, 10, 5, 1'b0, "b2b_a5");
      begin
        repeat (40) @(posedge clk);
        write0(8'h3C);
        chk({31'd0, tx_ready0}, 32'd0, "b2b_rdy");
        write0(8'h99);
        chk({31'd0, tx_ready0}, 32'd0, "b2b_rdy2");
      end
    join
    frame(1'b0, {2'b01, 8'h3C, 1'b0}, 10, 0, 1'b1, "b2b_3c");
    chk({31'd0, tx_ready0}, 32'd1, "b2b_drain");

    // TX FIFO mode, two bytes queued
    @(posedge clk);
    #1;
    fifo_n = 2;
    frame(1'b1, {2'b01, 8'h12, 1'b0}, 10, 10, 1'b0, "fifo_12");
    frame(1'b1, {2'b01, 8'h34, 1'b0}, 10, 0, 1'b1, "fifo_34");
    chk(rd_cnt, 2, "fifo_pops");
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    chk(lows, 0, "fifo_quiet");
    chk(rd_cnt, 2, "fifo_nopop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
